// File: rtl/nova_cfg_loader.sv
// nova_cfg_loader: buffers {uid,word,last} config records and strobes them
// onto the NovaCORE fabric config port, then releases the fabric to run mode.
module nova_cfg_loader #(
  parameter int CBUS_W     = 18,
  parameter int UID_W      = 4,
  parameter int N_TILES    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CCLK_LO    = 2,
  parameter int CCLK_HI    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [UID_W-1:0]  s_uid,
  input  logic [CBUS_W-1:0] s_word,
  input  logic              s_last,
  input  logic              reconfig,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       words_sent,
  output logic              mode,
  output logic [CBUS_W-1:0] c_bus,
  output logic [UID_W-1:0]  c_uid,
  output logic              c_clk
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int DW   = 1 + UID_W + CBUS_W;
  localparam int TMAX = (CCLK_LO > CCLK_HI) ? CCLK_LO : CCLK_HI;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RUN
  } state_e;

  logic [DW-1:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wp_q, rp_q;
  logic [AW:0]       cnt_q;
  logic              full, empty, push, pop;
  logic [DW-1:0]     head;
  logic              head_last;
  logic [UID_W-1:0]  head_uid;
  logic [CBUS_W-1:0] head_word;
  logic              uid_ok;

  state_e            state_q, state_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic              last_q, last_d;
  logic [CBUS_W-1:0] c_bus_q, c_bus_d;
  logic [UID_W-1:0]  c_uid_q, c_uid_d;
  logic              err_q, err_d;
  logic [15:0]       ws_q, ws_d;
  logic              c_clk_q, mode_q, done_q;

  assign full      = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign empty     = (cnt_q == '0);
  assign s_ready   = !full && (state_q != S_RUN);
  assign push      = s_valid && s_ready && !reconfig;
  assign head      = mem_q[rp_q];
  assign head_last = head[DW-1];
  assign head_uid  = head[CBUS_W +: UID_W];
  assign head_word = head[CBUS_W-1:0];
  assign uid_ok    = ({1'b0, head_uid} < (UID_W+1)'(N_TILES));

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wp_q] <= {s_last, s_uid, s_word};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || reconfig) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + AW'(1);
      if (pop)  rp_q <= rp_q + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    last_d  = last_q;
    c_bus_d = c_bus_q;
    c_uid_d = c_uid_q;
    err_d   = err_q;
    ws_d    = ws_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (uid_ok) begin
            c_bus_d = head_word;
            c_uid_d = head_uid;
            last_d  = head_last;
            tmr_d   = '0;
            state_d = S_SETUP;
          end else begin
            err_d = 1'b1;
            if (head_last) state_d = S_RUN;
          end
        end
      end
      S_SETUP: begin
        if (tmr_q == TW'(CCLK_LO - 1)) begin
          tmr_d   = '0;
          state_d = S_STROBE;
          if (ws_q != 16'hFFFF) ws_d = ws_q + 16'd1;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_STROBE: begin
        if (tmr_q == TW'(CCLK_HI - 1)) begin
          tmr_d   = '0;
          state_d = S_HOLD;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_HOLD:  state_d = last_q ? S_RUN : S_IDLE;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
    // Flush wins over everything, including a pop or push this cycle
    if (reconfig) begin
      state_d = S_IDLE;
      tmr_d   = '0;
      pop     = 1'b0;
      err_d   = 1'b0;
      ws_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      last_q  <= 1'b0;
      c_bus_q <= '0;
      c_uid_q <= '0;
      err_q   <= 1'b0;
      ws_q    <= '0;
      c_clk_q <= 1'b0;
      mode_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      last_q  <= last_d;
      c_bus_q <= c_bus_d;
      c_uid_q <= c_uid_d;
      err_q   <= err_d;
      ws_q    <= ws_d;
      c_clk_q <= (state_d == S_STROBE);
      mode_q  <= (state_d != S_RUN);
      done_q  <= (state_d == S_RUN);
    end
  end

  assign busy       = (state_q == S_SETUP) || (state_q == S_STROBE) ||
                      (state_q == S_HOLD);
  assign done       = done_q;
  assign err        = err_q;
  assign words_sent = ws_q;
  assign mode       = mode_q;
  assign c_bus      = c_bus_q;
  assign c_uid      = c_uid_q;
  assign c_clk      = c_clk_q;

endmodule
